// File: rtl/debounce_pkg.sv
// Shared defaults and types for the multi-channel switch debouncer.
package debounce_pkg;

    localparam int DB_N_CH         = 4;
    localparam int DB_STABLE_TICKS = 8;
    localparam int DB_SYNC_STAGES  = 2;

    typedef struct packed {
        logic rise;
        logic fall;
    } db_edge_t;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, tick-qualified stability counter,
// registered clean level and one-cycle rise/fall strobes.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DB_STABLE_TICKS,
    parameter int SYNC_STAGES  = DB_SYNC_STAGES,
    parameter int CNT_W        = $clog2(STABLE_TICKS + 1)
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     tick,
    input  logic     sw,
    output logic     db,
    output db_edge_t strobe,
    output db_edge_t strobe_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    db_edge_t               edge_q, edge_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every _d signal gets a default before any branch, so no path can infer a latch.
        sync_d = {sync_q[SYNC_STAGES-2:0], sw};
        cnt_d  = cnt_q;
        db_d   = db_q;
        edge_d = '0;
        if (s == db_q) begin
            // Bounce back to the current level cancels any qualification in progress.
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
                db_d        = s;
                cnt_d       = '0;
                edge_d.rise = s;
                edge_d.fall = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchroniser is cleared too, so no pre-reset level is still in flight afterwards.
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            edge_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            edge_q <= edge_d;
        end
    end

    assign db         = db_q;
    assign strobe     = edge_q;
    assign strobe_nxt = edge_d;

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debounce channels plus a registered any_change flag
// that is aligned with the per-channel rise/fall strobes.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = DB_N_CH,
    parameter int STABLE_TICKS = DB_STABLE_TICKS,
    parameter int SYNC_STAGES  = DB_SYNC_STAGES,
    parameter int CNT_W        = $clog2(STABLE_TICKS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_change
);

    db_edge_t [N_CH-1:0] strobe;
    db_edge_t [N_CH-1:0] strobe_nxt;
    logic                any_change_q, any_change_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .sw         (sw[i]),
            .db         (db[i]),
            .strobe     (strobe[i]),
            .strobe_nxt (strobe_nxt[i])
        );
        assign rise[i] = strobe[i].rise;
        assign fall[i] = strobe[i].fall;
    end

    // Built from next-state strobes so the flag lands in the same cycle as rise/fall.
    always_comb begin
        any_change_d = |strobe_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a tick-counting reference model.
module tb_debounce_multi;

    localparam int N  = 4;
    localparam int ST = 4;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] db, rise, fall;
    logic         any_change;

    int n_checks = 0;
    int n_errors = 0;

    debounce_multi #(
        .N_CH         (N),
        .STABLE_TICKS (ST),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .sw         (sw),
        .db         (db),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the synchroniser is a plain SS-deep delay line of sw
    // samples, and a channel flips once ST ticks have been seen while its
    // delayed input continuously disagreed with the clean level.
    logic [N-1:0] m_pipe[$];
    logic [N-1:0] m_s, m_db, m_rise, m_fall;
    logic         m_any;
    int           m_ticks[N];
    bit           model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            m_any  = 1'b0;
            for (int i = 0; i < N; i++) m_ticks[i] = 0;
            m_pipe.delete();
            for (int i = 0; i < SS; i++) m_pipe.push_back('0);
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_s = m_pipe[SS-1];
            m_pipe.push_front(sw);
            void'(m_pipe.pop_back());
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s[i] == m_db[i]) begin
                    m_ticks[i] = 0;
                end else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == ST) begin
                        m_db[i]    = m_s[i];
                        m_rise[i]  = m_s[i];
                        m_fall[i]  = !m_s[i];
                        m_ticks[i] = 0;
                    end
                end
            end
            m_any = |(m_rise | m_fall);
        end
    end

    always @(negedge clk) begin
        if (model_valid)
            check("model_compare {db,rise,fall,any}", {db, rise, fall, any_change},
                  {m_db, m_rise, m_fall, m_any});
    end

    // Tick source: 0 = always on, 1 = every 10 clocks, 2 = random.
    int tick_mode = 0;
    int pre_cnt   = 0;

    task automatic step();
        @(negedge clk);
        pre_cnt++;
        case (tick_mode)
            0:       tick = 1'b1;
            1:       tick = (pre_cnt % 10 == 0);
            default: tick = ($urandom_range(0, 2) == 0);
        endcase
    endtask

    task automatic settle();
        tick_mode = 0;
        rst = 1'b0;
        sw = '0;
        repeat (12) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  seen;

        // Reset with all switches high: everything must stay zero.
        tick_mode = 0;
        rst = 1'b1;
        sw  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset db", db, 0);
            check("reset strobes", {rise, fall, any_change}, 0);
        end
        settle();

        // Clean press on channel 0 with tick held high.
        step();
        sw[0] = 1'b1;
        repeat (5) step();
        check("press db before edge 5", db[0], 0);
        step();
        check("press db after edge 5", db[0], 1);
        check("press rise[0]", rise, 4'h1);
        check("press any_change", any_change, 1);
        step();
        check("press rise one cycle", rise[0], 0);

        // Bounce on channel 1: three clocks high is not enough.
        settle();
        step();
        sw[1] = 1'b1;
        repeat (3) step();
        sw[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rise[1] || fall[1]) seen = 1'b1;
        end
        check("bounce db[1]", db[1], 0);
        check("bounce no strobe", seen, 0);
        sw[1] = 1'b1;
        repeat (6) step();
        check("bounce then hold db[1]", db[1], 1);

        // Prescaled tick on channel 2.
        settle();
        tick_mode = 1;
        pre_cnt   = 9;
        step();
        sw[2] = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            n++;
            if (db[2]) break;
        end
        check("prescaled db[2] rose", db[2], 1);
        check("prescaled latency in [30,42]", (n >= 30 && n <= 42), 1);

        settle();
        tick_mode = 1;
        pre_cnt   = 9;
        step();
        sw[2] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (db[2]) seen = 1'b1;
        end
        sw[2] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (db[2] || rise[2]) seen = 1'b1;
        end
        check("prescaled short pulse rejected", seen, 0);

        // All channels at once, then a partial release.
        settle();
        step();
        sw = 4'hF;
        repeat (5) step();
        check("multi db before", db, 4'h0);
        step();
        check("multi db rise", db, 4'hF);
        check("multi rise", rise, 4'hF);
        check("multi any_change", any_change, 1);
        step();
        check("multi rise one cycle", rise, 4'h0);
        sw = 4'h5;
        repeat (6) step();
        check("multi fall", fall, 4'hA);
        check("multi db after fall", db, 4'h5);
        check("multi fall no rise", rise, 4'h0);

        // Reset in the middle of qualifying channel 3.
        settle();
        step();
        sw[3] = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        step();
        check("mid-reset db", db, 4'h0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            n++;
            if (db[3]) break;
        end
        check("mid-reset requalify latency", n, SS + 4);

        // Randomized traffic with random ticks and occasional resets.
        settle();
        tick_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < N; b++) begin
                if (((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 39) == 0))
                    sw[b] = ~sw[b];
            end
        end
        rst = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
